// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: op encodings and FSM states.
package ex_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLT = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_BEQ = 4'd8,
        OP_BNE = 4'd9,
        OP_MUL = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier, one partial product per cycle, WIDTH cycles.
// start_i loads operands; done_o pulses during the final iteration cycle.
// product_o shows the finished product combinationally in that cycle and
// keeps showing the registered product afterwards.
module ex_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;

    // Accumulate the current partial product (multiplicand shifted to the bit position).
    always_comb begin
        acc_d = acc_q + (b_q[0] ? a_q : '0);
    end

    // Operand/accumulator registers; the iteration stops after the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            acc_q <= acc_d;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done_o    = run_q && (cnt_q == LAST);
    assign product_o = run_q ? acc_d : acc_q;

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: single-cycle ALU with a registered output slot, plus an
// iterative MUL that blocks intake until its product has been loaded.
// Handshake: a side transfers when its valid and ready are both high at a
// rising clock edge; out_* fields are held stable while out_valid && !out_ready.
module ex_stage_mc
    import ex_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int RD_W   = 6,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             use_imm,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [WIDTH-1:0] immediate,
    input  logic [WIDTH-1:0] pc,
    input  logic [RD_W-1:0]  rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] new_pc,
    output logic [WIDTH-1:0] imm_out,
    output logic [RD_W-1:0]  rd_out,
    output logic             branch,
    output logic             busy,
    output logic [1:0]       state_o
);

    localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] new_pc_q, new_pc_d;
    logic [WIDTH-1:0] imm_out_q, imm_out_d;
    logic [RD_W-1:0]  rd_out_q, rd_out_d;
    logic             branch_q, branch_d;

    // Side fields of the MUL in flight, frozen at transfer.
    logic [WIDTH-1:0] mpc_q, mimm_q;
    logic [RD_W-1:0]  mrd_q;

    logic             out_free, fire, is_mul, load_mul;
    logic [WIDTH-1:0] b_opnd, alu_res;
    logic             alu_br;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (state_q == ST_IDLE) && out_free;
    assign fire     = in_valid && in_ready;
    assign is_mul   = (MUL_EN != 0) && (op == OP_MUL);
    assign b_opnd   = use_imm ? immediate : dataB;
    assign load_mul = out_free && (((state_q == ST_MUL) && mul_done) || (state_q == ST_DONE));

    ex_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (fire && is_mul),
        .a_i      (dataA),
        .b_i      (b_opnd),
        .done_o   (mul_done),
        .product_o(mul_product)
    );

    // Single-cycle ALU; anything not listed (including MUL) yields zero here.
    always_comb begin
        alu_res = '0;
        alu_br  = 1'b0;
        case (op)
            OP_ADD: alu_res = dataA + b_opnd;
            OP_SUB: alu_res = dataA - b_opnd;
            OP_AND: alu_res = dataA & b_opnd;
            OP_OR:  alu_res = dataA | b_opnd;
            OP_XOR: alu_res = dataA ^ b_opnd;
            OP_SLT: alu_res = ($signed(dataA) < $signed(b_opnd)) ? WIDTH'(1) : '0;
            OP_SLL: alu_res = dataA << b_opnd[SH_W-1:0];
            OP_SRL: alu_res = dataA >> b_opnd[SH_W-1:0];
            OP_BEQ: begin
                alu_res = dataA - b_opnd;
                alu_br  = (dataA == b_opnd);
            end
            OP_BNE: begin
                alu_res = dataA - b_opnd;
                alu_br  = (dataA != b_opnd);
            end
            default: begin
                alu_res = '0;
                alu_br  = 1'b0;
            end
        endcase
    end

    // Next-state logic: MUL waits in DONE only if the output slot is still occupied.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fire && is_mul) state_d = ST_MUL;
            ST_MUL:  if (mul_done) state_d = out_free ? ST_IDLE : ST_DONE;
            ST_DONE: if (out_free) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output slot next value: hold, drop on consumption, or load ALU/MUL result.
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        new_pc_d    = new_pc_q;
        imm_out_d   = imm_out_q;
        rd_out_d    = rd_out_q;
        branch_d    = branch_q;
        if (fire && !is_mul) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            new_pc_d    = pc + immediate;
            imm_out_d   = immediate;
            rd_out_d    = rd;
            branch_d    = alu_br;
        end else if (load_mul) begin
            out_valid_d = 1'b1;
            result_d    = mul_product;
            new_pc_d    = mpc_q;
            imm_out_d   = mimm_q;
            rd_out_d    = mrd_q;
            branch_d    = 1'b0;
        end
    end

    // State and output-slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            new_pc_q    <= '0;
            imm_out_q   <= '0;
            rd_out_q    <= '0;
            branch_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            new_pc_q    <= new_pc_d;
            imm_out_q   <= imm_out_d;
            rd_out_q    <= rd_out_d;
            branch_q    <= branch_d;
        end
    end

    // Capture the MUL's side fields so input changes during iteration are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mpc_q  <= '0;
            mimm_q <= '0;
            mrd_q  <= '0;
        end else if (fire && is_mul) begin
            mpc_q  <= pc + immediate;
            mimm_q <= immediate;
            mrd_q  <= rd;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign new_pc    = new_pc_q;
    assign imm_out   = imm_out_q;
    assign rd_out    = rd_out_q;
    assign branch    = branch_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_o   = state_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Bench for ex_stage_mc: directed scenarios followed by randomized traffic,
// checked against an arithmetic reference model and an in-order result queue.
module tb_ex_stage_mc;

  localparam int W  = 32;
  localparam int RW = 6;
  localparam int EW = 1 + RW + W + W + W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [3:0]    op;
  logic          use_imm;
  logic [W-1:0]  dataA, dataB, immediate, pc;
  logic [RW-1:0] rd;
  logic          out_valid, out_ready;
  logic [W-1:0]  result, new_pc, imm_out;
  logic [RW-1:0] rd_out;
  logic          branch, busy;
  logic [1:0]    state_o;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];

  ex_stage_mc dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .use_imm(use_imm),
    .dataA(dataA), .dataB(dataB), .immediate(immediate), .pc(pc), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .new_pc(new_pc), .imm_out(imm_out), .rd_out(rd_out),
    .branch(branch), .busy(busy), .state_o(state_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // reference model: what the stage must emit for one accepted operation
  function automatic logic [EW-1:0] model(input logic [3:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic ui,
                                          input logic [W-1:0] imm, input logic [W-1:0] p,
                                          input logic [RW-1:0] r);
    logic [W-1:0]   bv, res;
    logic           br;
    logic [2*W-1:0] prod;
    bv  = ui ? imm : b;
    res = '0;
    br  = 1'b0;
    case (o)
      4'd0:  res = a + bv;
      4'd1:  res = a - bv;
      4'd2:  res = a & bv;
      4'd3:  res = a | bv;
      4'd4:  res = a ^ bv;
      4'd5:  res = ($signed(a) < $signed(bv)) ? 32'd1 : 32'd0;
      4'd6:  res = a << bv[4:0];
      4'd7:  res = a >> bv[4:0];
      4'd8:  begin res = a - bv; br = (a == bv); end
      4'd9:  begin res = a - bv; br = (a != bv); end
      4'd10: begin prod = {32'b0, a} * {32'b0, bv}; res = prod[W-1:0]; end
      default: res = '0;
    endcase
    return {br, r, imm, p + imm, res};
  endfunction

  // driver tasks
  task automatic set_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ui, input logic [W-1:0] imm, input logic [W-1:0] p,
                        input logic [RW-1:0] r);
    op = o; dataA = a; dataB = b; use_imm = ui; immediate = imm; pc = p; rd = r;
    in_valid = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    if (in_valid && in_ready && !rst)
      exp_q.push_back(model(op, dataA, dataB, use_imm, immediate, pc, rd));
    @(posedge clk);
    #1;
  endtask

  // scoreboard and hold monitor
  logic [EW-1:0] snap;
  logic          hold_pend = 1'b0;

  always @(negedge clk) begin
    logic [EW-1:0] cur, e;
    cur = {branch, rd_out, imm_out, new_pc, result};
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", cur, snap);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_valid", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_out", cur, e);
        end
      end
      hold_pend = out_valid && !out_ready;
      snap = cur;
    end
  end

  // directed steps followed by random traffic
  initial begin
    logic [W-1:0] ra, rb, xe[4];
    logic [63:0]  prod;
    int           n;

    rst = 1'b1; in_valid = 1'b0; op = '0; use_imm = 1'b0;
    dataA = '0; dataB = '0; immediate = '0; pc = '0; rd = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_new_pc", new_pc, 0);
    chk("rst_imm_out", imm_out, 0);
    chk("rst_rd_out", rd_out, 0);
    chk("rst_branch", branch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_o, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    // ADD 5+7
    set_op(4'd0, 32'd5, 32'd7, 1'b0, 32'h20, 32'h100, 6'd3);
    #1 chk("add_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("add_valid", out_valid, 1);
    chk("add_result", result, 12);
    chk("add_new_pc", new_pc, 32'h120);
    chk("add_branch", branch, 0);
    chk("add_rd", rd_out, 3);

    // BEQ / BNE with equal operands
    set_op(4'd8, 32'h55, 32'h55, 1'b0, 32'h8, 32'h40, 6'd1);
    tick();
    chk("beq_branch", branch, 1);
    chk("beq_result", result, 0);
    set_op(4'd9, 32'h55, 32'h55, 1'b0, 32'h8, 32'h40, 6'd2);
    tick();
    in_valid = 1'b0;
    chk("bne_branch", branch, 0);

    // MUL 0xFFFFFFFF * 3 with inputs churning during iteration
    set_op(4'd10, 32'hFFFF_FFFF, 32'd3, 1'b0, 32'h10, 32'h200, 6'd7);
    #1 chk("mul_in_ready", in_ready, 1);
    tick();
    for (int i = 1; i <= 32; i++) begin
      set_op(4'd0, $urandom, $urandom, 1'b0, $urandom, $urandom, RW'($urandom));
      #1;
      chk("mul_busy", busy, 1);
      chk("mul_in_ready_low", in_ready, 0);
      chk("mul_no_valid", out_valid, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("mul_valid_c33", out_valid, 1);
    chk("mul_result", result, 32'hFFFF_FFFD);
    chk("mul_new_pc", new_pc, 32'h210);
    chk("mul_rd", rd_out, 7);
    chk("mul_busy_done", busy, 0);
    tick();

    // SUB 3-5 held under backpressure
    set_op(4'd1, 32'd3, 32'd5, 1'b0, 32'h4, 32'h0, 6'd9);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("sub_hold_valid", out_valid, 1);
      chk("sub_hold_result", result, 32'hFFFF_FFFE);
      chk("sub_hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("sub_consumed", out_valid, 0);

    // MUL finishing while downstream stalls
    ra = $urandom; rb = $urandom;
    set_op(4'd10, ra, rb, 1'b0, 32'h0, 32'h0, 6'd11);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (32) tick();
    prod = {32'b0, ra} * {32'b0, rb};
    chk("mul2_valid", out_valid, 1);
    chk("mul2_result", result, prod[31:0]);
    chk("mul2_busy", busy, 0);
    chk("mul2_in_ready", in_ready, 0);
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    chk("mul2_consumed", out_valid, 0);

    // reset pulsed at MUL cycle 10
    set_op(4'd10, $urandom, $urandom, 1'b0, 32'h0, 32'h0, 6'd5);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("mulrst_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("mulrst_valid", out_valid, 0);
    chk("mulrst_result", result, 0);
    chk("mulrst_new_pc", new_pc, 0);
    chk("mulrst_imm_out", imm_out, 0);
    chk("mulrst_rd_out", rd_out, 0);
    chk("mulrst_branch", branch, 0);
    chk("mulrst_busy", busy, 0);
    chk("mulrst_state", state_o, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    #1;
    chk("mulrst_in_ready", in_ready, 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("mulrst_no_valid", out_valid, 0);
    end

    // four back-to-back XORs
    for (int k = 0; k < 4; k++) begin
      ra = $urandom; rb = $urandom;
      xe[k] = ra ^ rb;
      set_op(4'd4, ra, rb, 1'b0, 32'h0, 32'h0, RW'(k));
      tick();
      chk("xor_valid", out_valid, 1);
      chk("xor_result", result, xe[k]);
    end
    in_valid = 1'b0;
    tick();

    // SLL by 0x25 uses only the low five bits
    set_op(4'd6, 32'd1, 32'h25, 1'b0, 32'h0, 32'h0, 6'd0);
    tick();
    in_valid = 1'b0;
    chk("sll_result", result, 32'h20);

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      logic [3:0] o;
      o = 4'($urandom_range(0, 15));
      if (o == 4'd10 && $urandom_range(0, 3) != 0) o = 4'd0;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      set_op(o, ra, rb, 1'($urandom_range(0, 1)), $urandom, $urandom, RW'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // drain
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", (n < 200), 1);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage_mc.md
EX_STAGE_MC -- requirements
Module: ex_stage_mc

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data, PC and immediate width.
REQ-002 Parameter RD_W, default 6, SHALL set the destination-register tag width.
REQ-003 Parameter MUL_EN, default 1, SHALL enable the multi-cycle MUL op when set; when 0, MUL SHALL be treated as an undefined op.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  upstream operation present.
REQ-007 in_ready  out  1  stage accepts an operation this cycle.
REQ-008 op  in  4  operation code, encodings from ex_pkg.
REQ-009 use_imm  in  1  1: ALU B operand = immediate; 0: ALU B operand = dataB.
REQ-010 dataA, dataB, immediate, pc  in  WIDTH each  operands, immediate and instruction PC.
REQ-011 rd  in  RD_W  destination tag.
REQ-012 out_valid  out  1  output register holds a result.
REQ-013 out_ready  in  1  downstream consumes the result.
REQ-014 result, new_pc, imm_out  out  WIDTH each  ALU result, branch target, passed-through immediate.
REQ-015 rd_out  out  RD_W  passed-through tag.
REQ-016 branch  out  1  branch taken.
REQ-017 busy  out  1  multi-cycle op in flight.

Function
REQ-018 An operation SHALL transfer when in_valid && in_ready are both high at a clock edge.
REQ-019 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-020 ADD/SUB/AND/OR/XOR SHALL compute A op B modulo 2^WIDTH.
REQ-021 SLT SHALL return 1 if A < B (signed), else 0.
REQ-022 SLL/SRL SHALL shift A by B[log2(WIDTH)-1:0]; SRL SHALL be logical.
REQ-023 BEQ/BNE SHALL set result = A-B and branch = (A==B) / (A!=B); branch SHALL be 0 for all other ops.
REQ-024 new_pc SHALL be pc + immediate modulo 2^WIDTH for every op.
REQ-025 Undefined ops SHALL produce result 0 and branch 0.
REQ-026 Single-cycle ops SHALL appear on the outputs with out_valid=1 one cycle after transfer, giving back-to-back throughput of 1 op per cycle while out_ready=1.
REQ-027 MUL SHALL return the low WIDTH bits of the unsigned product A*B using a shift-add iteration of WIDTH cycles.
REQ-028 MUL SHALL present out_valid=1 WIDTH+1 cycles after transfer, provided the output register is free.
REQ-029 States: IDLE -> MUL on MUL transfer; MUL -> IDLE after WIDTH iterations if (!out_valid || out_ready), else MUL -> DONE; DONE -> IDLE when (!out_valid || out_ready), loading the product.
REQ-030 busy SHALL be 1 in states MUL and DONE.
REQ-031 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-032 out_valid SHALL clear after consumption unless a new result loads on the same edge.
REQ-033 pc, immediate and rd for a MUL SHALL be captured at transfer and SHALL NOT be affected by input changes during iteration.

Reset
REQ-034 rst SHALL immediately force state=IDLE and set out_valid, result, new_pc, imm_out, rd_out, branch and busy to 0.
REQ-035 rst asserted mid-MUL SHALL abandon the operation; no result SHALL appear after release.
REQ-036 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-037 Package ex_pkg SHALL hold the op encodings (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SRL=7, BEQ=8, BNE=9, MUL=10) and the state enum.
REQ-038 The iterative multiplier SHALL be a sub-module ex_mul_seq with start/done handshake; the single-cycle ALU and output register SHALL stay in ex_stage_mc.

Verification
REQ-039 Scenario: ADD A=5, B=7, use_imm=0, pc=0x100, imm=0x20, out_ready=1 -> next cycle: out_valid=1, result=12, new_pc=0x120, branch=0.
REQ-040 Scenario: BEQ A=B=0x55 -> branch=1, result=0; then BNE with same operands -> branch=0.
REQ-041 Scenario: MUL A=0xFFFF_FFFF, B=3 -> busy for 32 cycles, then out_valid=1 at cycle 33 with result=0xFFFF_FFFD, and in_ready=0 throughout.
REQ-042 Scenario: out_ready=0 for 5 cycles after an SUB 3-5 -> result=0xFFFF_FFFE held stable, in_ready=0; MUL completing meanwhile -> state DONE until the result is consumed.
REQ-043 Scenario: rst pulsed at MUL cycle 10 -> all outputs 0 immediately; no out_valid afterward; in_ready=1 next cycle.
REQ-044 Scenario: 4 back-to-back XOR ops with out_ready=1 -> 4 consecutive out_valid cycles in order; SLL A=1, B=0x25 -> result=0x20.
